// File: rtl/wf_playout_pkg.sv
// Shared encodings for the waveform playout reader: FSM states and the
// bit positions of the length field and of the I/Q halves of a beat.
package wf_playout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } wfp_state_t;

  localparam int WFP_LEN_LSB = 0;
  localparam int WFP_LEN_MSB = 31;
  localparam int I_LSB       = 0;
  localparam int Q_LSB       = 16;
  localparam int SAMPLE_W    = 16;

endpackage

// File: rtl/waveform_playout.sv
// Plays one stored waveform from the wfout AXI-stream to the DAC path as
// registered 16-bit I/Q, checking beat count against the programmed length.
module waveform_playout
  import wf_playout_pkg::*;
#(
  parameter int LEN_W     = 32,
  parameter int DRAIN_MAX = 4096
) (
  input  logic             clk_in1,
  input  logic             reset,
  input  logic [127:0]     waveform_parameters,
  input  logic             wf_read_ready,
  input  logic             play_trigger,
  input  logic             play_enable,
  input  logic [31:0]      wfout_axis_tdata,
  input  logic             wfout_axis_tvalid,
  input  logic             wfout_axis_tlast,
  input  logic [3:0]       wfout_axis_tkeep,
  output logic             wfout_axis_tready,
  output logic [15:0]      dac_out_i,
  output logic [15:0]      dac_out_q,
  output logic             dac_out_valid,
  output logic             play_active,
  output logic             play_done,
  output logic [LEN_W-1:0] sample_count,
  output logic             underflow_err,
  output logic             tlast_err,
  output logic             trig_overrun,
  input  logic             err_clear
);

  localparam int DRAIN_W = $clog2(DRAIN_MAX + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  localparam logic [LEN_W-1:0]   COUNT_MAX  = '1;

  // state is the FSM register; checkers bind to it directly.
  wfp_state_t         state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   param_len;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               beat;
  logic               at_last;
  logic               busy;
  logic               trig_start;
  logic               uf_set;
  logic               tl_set;
  logic               tr_set;
  logic               unused_bits;

  assign param_len   = LEN_W'(waveform_parameters[WFP_LEN_MSB:WFP_LEN_LSB]);
  assign unused_bits = ^{waveform_parameters[127:WFP_LEN_MSB+1], wfout_axis_tkeep};

  // Handshake: a beat transfers on any clock where tvalid and tready are both
  // high; tready depends only on state, never on tvalid.
  assign wfout_axis_tready = (state == ST_PLAY) || (state == ST_DRAIN);
  assign beat              = wfout_axis_tvalid && wfout_axis_tready;
  assign at_last           = (sample_count == len - LEN_W'(1));

  // The play_done cycle still counts as busy so a trigger there is refused.
  assign busy       = (state != ST_IDLE) || play_done;
  assign trig_start = play_trigger && play_enable && !busy;
  assign tr_set     = play_trigger && busy;
  assign uf_set     = (state == ST_PLAY) && !wfout_axis_tvalid && (sample_count != '0);
  assign tl_set     = (state == ST_PLAY) && beat && (wfout_axis_tlast != at_last);

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state         <= ST_IDLE;
      len           <= '0;
      drain_cnt     <= '0;
      dac_out_i     <= '0;
      dac_out_q     <= '0;
      dac_out_valid <= 1'b0;
      play_active   <= 1'b0;
      play_done     <= 1'b0;
      sample_count  <= '0;
      underflow_err <= 1'b0;
      tlast_err     <= 1'b0;
      trig_overrun  <= 1'b0;
    end else begin
      play_done     <= 1'b0;
      dac_out_valid <= 1'b0;
      dac_out_i     <= '0;
      dac_out_q     <= '0;
      underflow_err <= !err_clear && (underflow_err || uf_set);
      tlast_err     <= !err_clear && (tlast_err || tl_set);
      trig_overrun  <= !err_clear && (trig_overrun || tr_set);

      case (state)
        ST_IDLE: begin
          if (trig_start) begin
            len          <= param_len;
            sample_count <= '0;
            if (param_len == '0) begin
              play_done <= 1'b1;
            end else begin
              state       <= ST_ARM;
              play_active <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (wf_read_ready) state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (beat) begin
            dac_out_valid <= 1'b1;
            dac_out_i     <= wfout_axis_tdata[I_LSB +: SAMPLE_W];
            dac_out_q     <= wfout_axis_tdata[Q_LSB +: SAMPLE_W];
            if (sample_count != COUNT_MAX) sample_count <= sample_count + LEN_W'(1);
            if (wfout_axis_tlast) begin
              state       <= ST_IDLE;
              play_active <= 1'b0;
              play_done   <= 1'b1;
            end else if (at_last) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          // Flush the overlong frame, but never wait on the source forever.
          if ((beat && wfout_axis_tlast) || (drain_cnt == DRAIN_LAST)) begin
            state       <= ST_IDLE;
            play_active <= 1'b0;
            play_done   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_playout.sv
// Randomised and directed frames against a frame-level model: which beats must
// reach the DAC (and on which cycle), final count, flags and done pulses.
module tb_waveform_playout;

  localparam int LEN_W      = 32;
  localparam int DRAIN_MAX  = 4096;
  localparam int WAIT_LIMIT = 40;

  logic             clk_in1 = 1'b0;
  logic             reset;
  logic [127:0]     waveform_parameters;
  logic             wf_read_ready;
  logic             play_trigger;
  logic             play_enable;
  logic [31:0]      wfout_axis_tdata;
  logic             wfout_axis_tvalid;
  logic             wfout_axis_tlast;
  logic [3:0]       wfout_axis_tkeep;
  logic             wfout_axis_tready;
  logic [15:0]      dac_out_i;
  logic [15:0]      dac_out_q;
  logic             dac_out_valid;
  logic             play_active;
  logic             play_done;
  logic [LEN_W-1:0] sample_count;
  logic             underflow_err;
  logic             tlast_err;
  logic             trig_overrun;
  logic             err_clear;

  waveform_playout #(.LEN_W(LEN_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk_in1             (clk_in1),
    .reset               (reset),
    .waveform_parameters (waveform_parameters),
    .wf_read_ready       (wf_read_ready),
    .play_trigger        (play_trigger),
    .play_enable         (play_enable),
    .wfout_axis_tdata    (wfout_axis_tdata),
    .wfout_axis_tvalid   (wfout_axis_tvalid),
    .wfout_axis_tlast    (wfout_axis_tlast),
    .wfout_axis_tkeep    (wfout_axis_tkeep),
    .wfout_axis_tready   (wfout_axis_tready),
    .dac_out_i           (dac_out_i),
    .dac_out_q           (dac_out_q),
    .dac_out_valid       (dac_out_valid),
    .play_active         (play_active),
    .play_done           (play_done),
    .sample_count        (sample_count),
    .underflow_err       (underflow_err),
    .tlast_err           (tlast_err),
    .trig_overrun        (trig_overrun),
    .err_clear           (err_clear)
  );

  // ---------------- clock / reset ----------------
  always #2 clk_in1 = ~clk_in1;

  int cyc = 0;
  always @(posedge clk_in1) cyc <= cyc + 1;

  initial begin
    #240000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  int acc_total = 0;
  int done_cnt = 0;
  int frame_base = 0;
  int frame_play = 0;
  logic [63:0] exp_q[$];   // {cycle the sample must appear on, tdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk_in1) begin
    logic [63:0] e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0][63:32] == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("dac_sample", 64'({dac_out_valid, dac_out_q, dac_out_i}), {31'd0, 1'b1, e[31:0]});
      end else begin
        check("dac_idle", 64'({dac_out_valid, dac_out_q, dac_out_i}), 64'd0);
      end
      if (wfout_axis_tvalid && wfout_axis_tready) begin
        if (acc_total - frame_base < frame_play) exp_q.push_back({32'(cyc + 1), wfout_axis_tdata});
        acc_total++;
      end
      if (play_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic run_frame(input string tag, input int len, input int nbeats, input int tlast_idx,
                           input bit ramp, input int gap_beat, input int gap_len, input bit rnd_gaps,
                           input int rr_delay, input int trig_beat, input bit hold_clear,
                           input int reset_beat, input bit trig_on_done, input int exp_accept);
    int n_play, base_done, accepted, w, g;
    bit acc, exp_uf, exp_tl, exp_tr, stuck;
    n_play    = (tlast_idx >= 0 && tlast_idx + 1 < len) ? tlast_idx + 1 : len;
    exp_uf    = 1'b0;
    exp_tl    = (tlast_idx != len - 1);
    exp_tr    = (trig_beat >= 0);
    base_done = done_cnt;
    frame_base = acc_total;
    frame_play = n_play;
    accepted  = 0;
    stuck     = 1'b0;
    acc       = 1'b0;
    waveform_parameters = {$urandom, $urandom, $urandom, 32'(len)};
    wf_read_ready = (rr_delay == 0);
    err_clear = hold_clear;
    play_trigger = 1'b1;
    tick();
    play_trigger = 1'b0;
    for (int k = 0; k < nbeats && !stuck; k++) begin
      g = (k == gap_beat) ? gap_len : 0;
      if (rnd_gaps && $urandom_range(0, 3) == 0) g += int'($urandom_range(1, 3));
      if (g > 0 && k >= 1 && k < n_play) exp_uf = 1'b1;
      wfout_axis_tvalid = 1'b0;
      wfout_axis_tlast  = 1'b0;
      repeat (g) tick();
      wfout_axis_tdata  = ramp ? {16'd0, 16'(k)} : $urandom;
      wfout_axis_tlast  = (k == tlast_idx);
      wfout_axis_tvalid = 1'b1;
      if (k == trig_beat) play_trigger = 1'b1;
      w = 0;
      forever begin
        @(negedge clk_in1);
        acc = wfout_axis_tready;
        if (k == 0 && w == 0) check({tag, "_active"}, 64'(play_active), 64'd1);
        if (k == 0 && !wf_read_ready) check({tag, "_arm_tready"}, 64'(wfout_axis_tready), 64'd0);
        tick();
        play_trigger = 1'b0;
        if (acc) break;
        w++;
        if (w >= rr_delay) wf_read_ready = 1'b1;
        if (w > WAIT_LIMIT) begin
          stuck = 1'b1;
          break;
        end
      end
      if (acc) accepted++;
      if (acc && k == reset_beat) begin
        check({tag, "_pre_rst_count"}, 64'(sample_count), 64'(reset_beat + 1));
        check({tag, "_pre_rst_overrun"}, 64'(trig_overrun), 64'(exp_tr));
        reset = 1'b1;
        wfout_axis_tvalid = 1'b0;
        wfout_axis_tlast  = 1'b0;
        tick();
        check({tag, "_rst_dac"}, 64'({dac_out_valid, dac_out_q, dac_out_i}), 64'd0);
        check({tag, "_rst_ctrl"}, 64'({wfout_axis_tready, play_active, play_done,
                                        underflow_err, tlast_err, trig_overrun}), 64'd0);
        check({tag, "_rst_count"}, 64'(sample_count), 64'd0);
        reset = 1'b0;
        err_clear = 1'b0;
        tick();
        return;
      end
    end
    wfout_axis_tvalid = 1'b0;
    wfout_axis_tlast  = 1'b0;
    play_trigger      = 1'b0;
    w = 0;
    while (play_active && w < 100) begin
      tick();
      w++;
    end
    check({tag, "_end_idle"}, 64'(play_active), 64'd0);
    if (!stuck) check({tag, "_done_now"}, 64'(play_done), 64'd1);
    check({tag, "_count"}, 64'(sample_count), 64'(n_play));
    check({tag, "_flags"}, 64'({underflow_err, tlast_err, trig_overrun}),
          hold_clear ? 64'd0 : 64'({exp_uf, exp_tl, exp_tr}));
    if (trig_on_done) begin
      play_trigger = 1'b1;
      tick();
      play_trigger = 1'b0;
      check({tag, "_trig_on_done"}, 64'({play_active, wfout_axis_tready, play_done}), 64'd0);
    end
    tick();
    tick();
    check({tag, "_done_pulses"}, 64'(done_cnt - base_done), 64'd1);
    check({tag, "_accepted"}, 64'(accepted), 64'(exp_accept));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check({tag, "_cleared"}, 64'({underflow_err, tlast_err, trig_overrun}), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    reset = 1'b1;
    waveform_parameters = '0;
    wf_read_ready = 1'b0;
    play_trigger = 1'b0;
    play_enable = 1'b0;
    wfout_axis_tdata = '0;
    wfout_axis_tvalid = 1'b0;
    wfout_axis_tlast = 1'b0;
    wfout_axis_tkeep = 4'hf;
    err_clear = 1'b0;
    repeat (3) tick();
    check("reset_dac", 64'({dac_out_valid, dac_out_q, dac_out_i}), 64'd0);
    check("reset_ctrl", 64'({wfout_axis_tready, play_active, play_done,
                             underflow_err, tlast_err, trig_overrun}), 64'd0);
    check("reset_count", 64'(sample_count), 64'd0);
    reset = 1'b0;
    play_enable = 1'b1;
    tick();

    //        tag          len  nb   tlast ramp gapb gapl rnd rr trig clr rstb tod accept
    run_frame("ramp128",   128, 128, 127,  1,   -1,  0,   0,  0, -1,  0,  -1,  0,  128);
    run_frame("gap40",     128, 128, 127,  1,   41,  3,   0,  0, -1,  0,  -1,  0,  128);
    run_frame("early63",   128, 64,  63,   1,   -1,  0,   0,  0, -1,  0,  -1,  0,  64);
    run_frame("over200",   128, 200, 199,  1,   -1,  0,   0,  2, -1,  0,  -1,  0,  200);
    run_frame("trigplay",  128, 128, 127,  1,   -1,  0,   0,  0, 70,  0,  -1,  0,  128);

    base = done_cnt;
    waveform_parameters = {$urandom, $urandom, $urandom, 32'd0};
    play_trigger = 1'b1;
    tick();
    play_trigger = 1'b0;
    check("len0_done", 64'(play_done), 64'd1);
    check("len0_ctrl", 64'({wfout_axis_tready, play_active}), 64'd0);
    check("len0_count_cleared", 64'(sample_count), 64'd0);
    tick();
    check("len0_after", 64'({play_done, wfout_axis_tready, play_active}), 64'd0);
    tick();
    check("len0_pulses", 64'(done_cnt - base), 64'd1);

    play_enable = 1'b0;
    waveform_parameters = {96'd0, 32'd5};
    play_trigger = 1'b1;
    tick();
    play_trigger = 1'b0;
    tick();
    check("disabled_trig", 64'({play_active, wfout_axis_tready, play_done}), 64'd0);
    play_enable = 1'b1;

    run_frame("rst50",     128, 128, 127,  1,   -1,  0,   0,  0, 20,  0,  50,  0,  51);
    run_frame("post_rst",  128, 128, 127,  1,   -1,  0,   0,  0, -1,  0,  -1,  0,  128);
    run_frame("drainmax",  4,   4200, -1,  0,   -1,  0,   0,  0, -1,  0,  -1,  0,  4 + DRAIN_MAX);
    run_frame("clr_hold",  20,  10,  9,    0,   5,   2,   0,  0, 3,   1,  -1,  0,  10);
    run_frame("trig_done", 3,   3,   2,    0,   -1,  0,   0,  1, -1,  0,  -1,  1,  3);

    for (int f = 0; f < 25; f++) begin
      int len, nb, tl, mode, np, tb;
      len  = int'($urandom_range(1, 40));
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        nb = len;
        tl = len - 1;
      end else if (mode == 1) begin
        tl = int'($urandom_range(0, len - 1));
        nb = tl + 1;
      end else begin
        nb = len + int'($urandom_range(1, 10));
        tl = nb - 1;
      end
      np = (tl + 1 < len) ? tl + 1 : len;
      tb = -1;
      if (np >= 2 && $urandom_range(0, 1) == 1) tb = int'($urandom_range(1, np - 1));
      run_frame("rnd", len, nb, tl, 0, -1, 0, 1, int'($urandom_range(0, 4)), tb, 0, -1, 0, nb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
